spart_mmio: RTL

Memory-mapped serial port (UART-style, 8N1) that responds to the processor data bus as an MMIO peripheral, next to the LED/switch registers. It decodes a four-word window and accepts byte writes into an 8-entry transmit queue. It serializes those bytes onto `txd_o`, deserializes `rxd_i` into an 8-entry receive queue, and returns queue data, status and the baud divisor on reads. The top level ORs `hit_o` into its read-data mux.

---
 rtl/spart_pkg.sv | 23 ++
 rtl/spart_fifo.sv | 53 +++++
 rtl/spart_mmio.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared constants and state types for the memory-mapped serial port.
// Imported by the top level and the queue sub-module.
package spart_pkg;

    localparam logic [1:0] OFF_DATABUF = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DB      = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam logic [15:0] DB_DEFAULT = 16'd434;

    localparam int ST_FERR = 15;
    localparam int ST_OVR  = 14;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Divisors below 2 would leave no room for the half-bit start sample.
    function automatic logic [15:0] bit_period(input logic [15:0] db);
        return (db < 16'd2) ? 16'd2 : db;
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Power-of-two byte queue with first-word-fall-through head.
// A pop frees room for a same-cycle push when the queue is full.
module spart_fifo #(
    parameter int QDEPTH = 8,
    parameter int DW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(QDEPTH):0]  count_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [QDEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(QDEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spart_mmio.sv
// 8N1 serial port on the processor data bus: four-word register window,
// TX/RX byte queues, programmable baud divisor and sticky line errors.
module spart_mmio
    import spart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC004,
    parameter logic [15:0] DB_RESET  = DB_DEFAULT,
    parameter int          QDEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        hit_o,
    output logic        txd_o,
    input  logic        rxd_i
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [15:0] off;
    logic        sel_data, sel_status, sel_db;
    logic        wr_data, wr_status, wr_db;

    assign off        = addr_i - BASE_ADDR;
    assign hit_o      = (off[15:2] == 14'd0);
    assign sel_data   = hit_o & (off[1:0] == OFF_DATABUF);
    assign sel_status = hit_o & (off[1:0] == OFF_STATUS);
    assign sel_db     = hit_o & (off[1:0] == OFF_DB);
    assign wr_data    = we_i & sel_data;
    assign wr_status  = we_i & sel_status;
    assign wr_db      = we_i & sel_db;

    logic [15:0] db_q, period, half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        db_q <= DB_RESET;
        else if (wr_db) db_q <= wdata_i;
    end

    assign period = bit_period(db_q);
    assign half   = period >> 1;

    logic [7:0]    tx_head, rx_head, rx_byte_q;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_cnt, rx_cnt, tx_free;
    logic          tx_push, tx_pop, rx_pop, rx_push_q;
    tx_state_t     tx_state_q;

    assign tx_pop  = (tx_state_q == TX_IDLE) & ~tx_empty;
    assign tx_push = wr_data & (~tx_full | tx_pop);
    assign rx_pop  = re_i & sel_data;
    assign tx_free = CW'(QDEPTH) - tx_cnt;

    spart_fifo #(.QDEPTH(QDEPTH), .DW(8)) u_txq (
        .clk(clk), .rst(rst), .push_i(tx_push), .data_i(wdata_i[7:0]),
        .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_cnt)
    );

    spart_fifo #(.QDEPTH(QDEPTH), .DW(8)) u_rxq (
        .clk(clk), .rst(rst), .push_i(rx_push_q), .data_i(rx_byte_q),
        .pop_i(rx_pop), .head_o(rx_head), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_cnt)
    );

    // ---------------- transmitter ----------------
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        txd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (!tx_empty) begin
                        tx_sh_q    <= tx_head;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                // First START cycle drops the line; the second expiry moves to data.
                TX_START: begin
                    if (tx_cnt_q != 16'd0) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (txd_q) begin
                        txd_q    <= 1'b0;
                        tx_cnt_q <= period - 16'd1;
                    end else begin
                        txd_q      <= tx_sh_q[0];
                        tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= period - 16'd1;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q != 16'd0) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (tx_bit_q == 3'd7) begin
                        txd_q      <= 1'b1;
                        tx_cnt_q   <= period - 16'd1;
                        tx_state_q <= TX_STOP;
                    end else begin
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                        tx_bit_q <= tx_bit_q + 3'd1;
                        tx_cnt_q <= tx_cnt_q + period - 16'd1;
                    end
                end
                // Leave one cycle early: the IDLE decision cycle is the stop bit's last.
                TX_STOP: begin
                    if (tx_cnt_q <= 16'd1) tx_state_q <= TX_IDLE;
                    else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign txd_o = txd_q;

    // ---------------- receiver ----------------
    rx_state_t   rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_ferr_set_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_byte_q     <= '0;
            rx_push_q     <= 1'b0;
            rx_ferr_set_q <= 1'b0;
        end else begin
            rx_push_q     <= 1'b0;
            rx_ferr_set_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_cnt_q   <= half - 16'd1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else if (rx_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_bit_q   <= '0;
                        rx_cnt_q   <= period - 16'd1;
                        rx_state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_cnt_q <= period - 16'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        if (rx_s2_q) begin
                            rx_push_q <= 1'b1;
                            rx_byte_q <= rx_sh_q;
                        end else begin
                            rx_ferr_set_q <= 1'b1;
                        end
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- sticky errors ----------------
    logic ferr_q, ovr_q, ferr_d, ovr_d, ovr_set;

    assign ovr_set = rx_push_q & rx_full & ~rx_pop;
    // Set wins over a same-cycle clear so no error is lost.
    assign ferr_d  = (ferr_q & ~wr_status) | rx_ferr_set_q;
    assign ovr_d   = (ovr_q  & ~wr_status) | ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    // ---------------- read mux ----------------
    logic [15:0] status;

    always_comb begin
        status          = 16'h0000;
        status[ST_FERR] = ferr_q;
        status[ST_OVR]  = ovr_q;
        status[7:4]     = 4'(tx_free);
        status[3:0]     = 4'(rx_cnt);
    end

    always_comb begin
        rdata_o = 16'h0000;
        if (hit_o) begin
            case (off[1:0])
                OFF_DATABUF: if (!rx_empty) rdata_o = {8'h00, rx_head};
                OFF_STATUS:  rdata_o = status;
                OFF_DB:      rdata_o = db_q;
                default:     rdata_o = 16'h0000;
            endcase
        end
    end

endmodule
